// File: rtl/alu_iter_unit.sv
// ALU with integrated funct3/funct7 control decoder. Non-shift ops finish in one cycle;
// shifts iterate SHIFT_STEP bits per cycle before loading the output register.
module alu_iter_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            op5,
  input  logic            funct7,
  input  logic [1:0]      ALUOP,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [3:0]      alu_ctrl,
  output logic            busy
);

  localparam int unsigned AW = $clog2(XLEN);
  localparam logic [AW:0] StepMax = SHIFT_STEP[AW:0];

  localparam logic [3:0] CtlAdd  = 4'b0000;
  localparam logic [3:0] CtlSub  = 4'b0001;
  localparam logic [3:0] CtlAnd  = 4'b0010;
  localparam logic [3:0] CtlOr   = 4'b0011;
  localparam logic [3:0] CtlXor  = 4'b0100;
  localparam logic [3:0] CtlSlt  = 4'b0101;
  localparam logic [3:0] CtlSltu = 4'b0110;
  localparam logic [3:0] CtlSll  = 4'b0111;
  localparam logic [3:0] CtlSrl  = 4'b1000;
  localparam logic [3:0] CtlSra  = 4'b1001;

  typedef enum logic {StIdle, StShift} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] sh_val_q, sh_val_d, sh_next;
  logic [AW-1:0]   rem_q, rem_d;
  logic [3:0]      sh_ctrl_q, sh_ctrl_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic [3:0]      ctrl_q, ctrl_d;

  logic [3:0]      dec_ctrl, load_ctrl;
  logic [XLEN-1:0] alu_res, load_val;
  logic [AW-1:0]   shamt;
  logic [AW:0]     rem_ext, step;
  logic            is_shift, accept, out_free, load;

  always_comb begin
    dec_ctrl = CtlAdd;
    unique case (ALUOP)
      2'b01: dec_ctrl = CtlSub;
      2'b10: begin
        unique case (funct3)
          3'b000:  dec_ctrl = (op5 && funct7) ? CtlSub : CtlAdd;
          3'b001:  dec_ctrl = CtlSll;
          3'b010:  dec_ctrl = CtlSlt;
          3'b011:  dec_ctrl = CtlSltu;
          3'b100:  dec_ctrl = CtlXor;
          3'b101:  dec_ctrl = funct7 ? CtlSra : CtlSrl;
          3'b110:  dec_ctrl = CtlOr;
          default: dec_ctrl = CtlAnd;
        endcase
      end
      default: dec_ctrl = CtlAdd;
    endcase
  end

  assign shamt    = src_b[AW-1:0];
  assign is_shift = (dec_ctrl == CtlSll) || (dec_ctrl == CtlSrl) || (dec_ctrl == CtlSra);

  // Shifts reaching this path have amount 0, so the operand passes through unchanged.
  always_comb begin
    alu_res = '0;
    unique case (dec_ctrl)
      CtlAdd:  alu_res = src_a + src_b;
      CtlSub:  alu_res = src_a - src_b;
      CtlAnd:  alu_res = src_a & src_b;
      CtlOr:   alu_res = src_a | src_b;
      CtlXor:  alu_res = src_a ^ src_b;
      CtlSlt:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      CtlSltu: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      default: alu_res = src_a;
    endcase
  end

  assign rem_ext = {1'b0, rem_q};
  assign step    = (rem_ext < StepMax) ? rem_ext : StepMax;

  always_comb begin
    sh_next = sh_val_q;
    unique case (sh_ctrl_q)
      CtlSll:  sh_next = sh_val_q << step;
      CtlSrl:  sh_next = sh_val_q >> step;
      default: sh_next = $signed(sh_val_q) >>> step;
    endcase
  end

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = !rst && (state_q == StIdle) && out_free;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      sh_val_q    <= '0;
      rem_q       <= '0;
      sh_ctrl_q   <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ctrl_q      <= '0;
    end else begin
      state_q     <= state_d;
      sh_val_q    <= sh_val_d;
      rem_q       <= rem_d;
      sh_ctrl_q   <= sh_ctrl_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ctrl_q      <= ctrl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && is_shift && (shamt != '0)) state_d = StShift;
      default: if ((rem_q == '0) && out_free) state_d = StIdle;
    endcase
  end

  always_comb begin
    load      = 1'b0;
    load_val  = alu_res;
    load_ctrl = dec_ctrl;
    sh_val_d  = sh_val_q;
    rem_d     = rem_q;
    sh_ctrl_d = sh_ctrl_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_shift && (shamt != '0)) begin
            sh_val_d  = src_a;
            rem_d     = shamt;
            sh_ctrl_d = dec_ctrl;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: begin
        if (rem_q != '0) begin
          sh_val_d = sh_next;
          rem_d    = rem_q - step[AW-1:0];
        end else if (out_free) begin
          load      = 1'b1;
          load_val  = sh_val_q;
          load_ctrl = sh_ctrl_q;
        end
      end
    endcase
    out_valid_d = load ? 1'b1 : (out_valid_q && !out_ready);
    result_d    = load ? load_val : result_q;
    zero_d      = load ? (load_val == '0) : zero_q;
    ctrl_d      = load ? load_ctrl : ctrl_q;
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign alu_ctrl  = ctrl_q;
  assign busy      = (state_q == StShift);

endmodule

// File: tb/tb_alu_iter_unit.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_alu_iter_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, op5, funct7, out_valid, out_ready, zero, busy;
  logic [1:0]  ALUOP;
  logic [2:0]  funct3;
  logic [31:0] src_a, src_b, result;
  logic [3:0]  alu_ctrl;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, zero4, busy4;
  logic [31:0] src_a4, src_b4, result4;
  logic [3:0]  alu_ctrl4;

  always #5 clk = ~clk;

  alu_iter_unit #(.XLEN(32), .SHIFT_STEP(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op5(op5),
    .funct7(funct7), .ALUOP(ALUOP), .funct3(funct3), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .alu_ctrl(alu_ctrl), .busy(busy)
  );

  alu_iter_unit #(.XLEN(32), .SHIFT_STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .op5(1'b0),
    .funct7(1'b0), .ALUOP(2'b10), .funct3(3'b001), .src_a(src_a4), .src_b(src_b4),
    .out_valid(out_valid4), .out_ready(out_ready4), .result(result4), .zero(zero4),
    .alu_ctrl(alu_ctrl4), .busy(busy4)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  ctrl;
    logic        zero;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  exp_t held;
  bit   cur_checked = 0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      cur_checked = 0;
    end else if (out_valid) begin
      if (!cur_checked) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got result %h with no pending op", result);
        end else begin
          mon_e = q.pop_front();
          check("result", result, mon_e.res);
          check("alu_ctrl", {28'b0, alu_ctrl}, {28'b0, mon_e.ctrl});
          check("zero", {31'b0, zero}, {31'b0, mon_e.zero});
          if (mon_e.lat >= 0) check("latency", cyc - mon_e.acc, mon_e.lat);
          held = mon_e;
        end
        cur_checked = 1;
      end else begin
        check("hold_result", result, held.res);
        check("hold_ctrl", {28'b0, alu_ctrl}, {28'b0, held.ctrl});
        check("hold_zero", {31'b0, zero}, {31'b0, held.zero});
      end
      if (out_ready) cur_checked = 0;
    end
  end

  // lat is edges from the accept edge to the edge that raises out_valid.
  task automatic issue(input logic [1:0] aluop, input logic [2:0] f3, input logic o5,
                       input logic f7, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic [3:0] exp_ctrl,
                       input int lat);
    exp_t e;
    ALUOP = aluop; funct3 = f3; op5 = o5; funct7 = f7; src_a = a; src_b = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.res = exp_res; e.ctrl = exp_ctrl; e.zero = (exp_res == 32'd0);
        e.lat = lat; e.acc = cyc + 1;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL issue_timeout: in_ready stayed 0, required 1");
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0) return;
      @(posedge clk);
      #1;
    end
    total++;
    bad++;
    $display("FAIL drain_timeout: %0d results pending, required 0", q.size());
    q.delete();
  endtask

  task automatic run4(input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int n;
    src_a4 = 32'd1; src_b4 = b; in_valid4 = 1'b1;
    @(negedge clk);
    check("in_ready4", {31'b0, in_ready4}, 32'd1);
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid4) break;
      @(posedge clk);
      #1;
      n++;
    end
    check("latency4", n, exp_lat);
    check("result4", result4, exp_res);
    check("alu_ctrl4", {28'b0, alu_ctrl4}, 32'd7);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op5 = 1'b0; funct7 = 1'b0;
    ALUOP = 2'b00; funct3 = 3'b000; src_a = '0; src_b = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; src_a4 = '0; src_b4 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("in_ready_in_reset", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_ctrl", {28'b0, alu_ctrl}, 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back single-cycle ops.
    issue(2'b10, 3'b000, 1'b1, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE, 4'b0001, 0);
    issue(2'b10, 3'b000, 1'b0, 1'b1, 32'd5, 32'd7, 32'd12, 4'b0000, 0);
    issue(2'b01, 3'b000, 1'b0, 1'b0, 32'h1234, 32'h1234, 32'd0, 4'b0001, 0);
    issue(2'b10, 3'b010, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0101, 0);
    issue(2'b10, 3'b011, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0110, 0);
    issue(2'b10, 3'b100, 1'b1, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 4'b0100, 0);
    issue(2'b10, 3'b110, 1'b1, 1'b0, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 4'b0011, 0);
    issue(2'b11, 3'b101, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd1, 4'b0000, 0);
    issue(2'b10, 3'b001, 1'b1, 1'b0, 32'h1234, 32'd32, 32'h1234, 4'b0111, 0);
    wait_drain();

    issue(2'b10, 3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000, 4'b1001, 5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("busy_during_shift", {31'b0, busy}, 32'd1);
      check("in_ready_during_shift", {31'b0, in_ready}, 32'd0);
    end
    wait_drain();
    check("busy_after_shift", {31'b0, busy}, 32'd0);
    issue(2'b10, 3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000, 4'b1000, 5);
    wait_drain();

    // Backpressure, then drain and new load on the same edge.
    out_ready = 1'b0;
    issue(2'b00, 3'b000, 1'b0, 1'b0, 32'd3, 32'd4, 32'd7, 4'b0000, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(2'b00, 3'b000, 1'b0, 1'b0, 32'd10, 32'd20, 32'd30, 4'b0000, 0);
    check("b2b_out_valid", {31'b0, out_valid}, 32'd1);
    wait_drain();

    // Reset in the second shift cycle.
    issue(2'b10, 3'b001, 1'b0, 1'b0, 32'd1, 32'd8, 32'h0000_0100, 4'b0111, 9);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd0);
    check("rst_ctrl", {28'b0, alu_ctrl}, 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(2'b10, 3'b111, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 4'b0010, 0);
    wait_drain();

    // Four-bit shift steps.
    run4(32'h25, 32'h0000_0020, 3);
    run4(32'd31, 32'h8000_0000, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
